// File: rtl/spi_reg_bridge_if.sv
// Byte-stream and register-bus bundle between the SPI slave, the bridge and the register file.
// The bridge uses the master modport; the SPI slave / register-file side uses the slave modport.
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 7
);
  logic              frame_start;
  logic              frame_end;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (
    input  frame_start, frame_end, rx_valid, rx_byte, reg_rdata,
    output tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output frame_start, frame_end, rx_valid, rx_byte, reg_rdata,
    input  tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// Parses CS-framed SPI byte streams (<cmd><data...>) into register-bus reads and writes
// with address auto-increment; read data is handed back as the next byte to shift out.
module spi_reg_bridge #(
  parameter int         ADDR_W   = 7,
  parameter bit         AUTO_INC = 1'b1,
  parameter logic [7:0] IDLE_TX  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  spi_reg_bridge_if.master bus,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_WAIT,
    RD_STREAM
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(AUTO_INC);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] next_addr;

  assign cmd_addr  = ADDR_W'(bus.rx_byte[6:0]);
  assign next_addr = addr + ADDR_STEP;

  // frame_end outranks everything (including a coincident byte), then frame_start restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      busy          <= 1'b0;
      bus.tx_byte   <= IDLE_TX;
      bus.tx_valid  <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
    end else begin
      bus.tx_valid <= 1'b0;
      bus.reg_we   <= 1'b0;
      bus.reg_re   <= 1'b0;
      if (bus.frame_end) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (bus.frame_start) begin
        state        <= CMD;
        busy         <= 1'b1;
        bus.tx_byte  <= IDLE_TX;
        bus.tx_valid <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          CMD: begin
            if (bus.rx_valid) begin
              addr <= cmd_addr;
              if (bus.rx_byte[7]) begin
                bus.reg_re   <= 1'b1;
                bus.reg_addr <= cmd_addr;
                state        <= RD_REQ;
              end else begin
                state <= WR;
              end
            end
          end
          WR: begin
            if (bus.rx_valid) begin
              bus.reg_we    <= 1'b1;
              bus.reg_addr  <= addr;
              bus.reg_wdata <= bus.rx_byte;
              bus.tx_byte   <= IDLE_TX;
              bus.tx_valid  <= 1'b1;
              addr          <= next_addr;
            end
          end
          // The strobe is already on the bus during this cycle; bytes arriving now are dropped.
          RD_REQ: state <= RD_WAIT;
          RD_WAIT: begin
            bus.tx_byte  <= bus.reg_rdata;
            bus.tx_valid <= 1'b1;
            state        <= RD_STREAM;
          end
          RD_STREAM: begin
            if (bus.rx_valid) begin
              addr         <= next_addr;
              bus.reg_re   <= 1'b1;
              bus.reg_addr <= next_addr;
              state        <= RD_REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: expected strobes and tx bytes are queued when stimulus
// is driven and checked (value and cycle) when the bridge produces them.
module tb_spi_reg_bridge;

  localparam logic [7:0] IDLE_TX = 8'hA5;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  int   cyc;
  int   vectors;
  int   miscompares;

  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t tx_q[$];
  exp_t mon_e;

  spi_reg_bridge_if #(.ADDR_W(7)) bus ();

  spi_reg_bridge #(
    .ADDR_W  (7),
    .AUTO_INC(1'b1),
    .IDLE_TX (IDLE_TX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: read data is addr ^ 8'hFF, available the cycle after reg_re.
  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= {1'b0, bus.reg_addr} ^ 8'hFF;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic fe, input logic rv,
                               input logic [7:0] b);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.rx_valid    = rv;
    bus.rx_byte     = b;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    tx_q.push_back('{a: 8'h00, d: IDLE_TX, c: cyc + 1});
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back('{a: a, d: d, c: cyc + 1});
    tx_q.push_back('{a: 8'h00, d: IDLE_TX, c: cyc + 1});
  endtask

  task automatic expect_read(input logic [7:0] a);
    rd_q.push_back('{a: a, d: 8'h00, c: cyc + 1});
    tx_q.push_back('{a: 8'h00, d: a ^ 8'hFF, c: cyc + 3});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("we_re_exclusive", {15'd0, bus.reg_we & bus.reg_re}, 16'd0);
      if (bus.reg_we) begin
        checkOutput("wr_expected", {15'd0, wr_q.size() != 0}, 16'd1);
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          checkOutput("wr_addr", {9'd0, bus.reg_addr}, {8'd0, mon_e.a});
          checkOutput("wr_data", {8'd0, bus.reg_wdata}, {8'd0, mon_e.d});
          checkOutput("wr_cycle", 16'(cyc), 16'(mon_e.c));
        end
      end
      if (bus.reg_re) begin
        checkOutput("rd_expected", {15'd0, rd_q.size() != 0}, 16'd1);
        if (rd_q.size() != 0) begin
          mon_e = rd_q.pop_front();
          checkOutput("rd_addr", {9'd0, bus.reg_addr}, {8'd0, mon_e.a});
          checkOutput("rd_cycle", 16'(cyc), 16'(mon_e.c));
        end
      end
      if (bus.tx_valid) begin
        checkOutput("tx_expected", {15'd0, tx_q.size() != 0}, 16'd1);
        if (tx_q.size() != 0) begin
          mon_e = tx_q.pop_front();
          checkOutput("tx_byte", {8'd0, bus.tx_byte}, {8'd0, mon_e.d});
          checkOutput("tx_cycle", 16'(cyc), 16'(mon_e.c));
        end
      end
    end
  end

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;

    $display("[TB] reset values");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tx_byte", {8'd0, bus.tx_byte}, {8'd0, IDLE_TX});
    checkOutput("rst_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    checkOutput("rst_reg_we", {15'd0, bus.reg_we}, 16'd0);
    checkOutput("rst_reg_re", {15'd0, bus.reg_re}, 16'd0);
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_reg_addr", {9'd0, bus.reg_addr}, 16'd0);
    checkOutput("rst_reg_wdata", {8'd0, bus.reg_wdata}, 16'd0);
    rst = 1'b0;
    idle_cycles(2);
    checkOutput("post_rst_busy", {15'd0, busy}, 16'd0);

    $display("[TB] write burst");
    frame_begin();
    checkOutput("wr_busy", {15'd0, busy}, 16'd1);
    send_byte(8'h10);
    expect_write(8'h10, 8'h11);
    send_byte(8'h11);
    expect_write(8'h11, 8'h22);
    send_byte(8'h22);
    idle_cycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_end_busy", {15'd0, busy}, 16'd0);
    idle_cycles(2);

    $display("[TB] read burst");
    frame_begin();
    expect_read(8'h05);
    send_byte(8'h85);
    idle_cycles(2);
    expect_read(8'h06);
    send_byte(8'h00);
    send_byte(8'h00);
    idle_cycles(1);
    expect_read(8'h07);
    send_byte(8'h00);
    idle_cycles(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    idle_cycles(2);

    $display("[TB] address wrap");
    frame_begin();
    send_byte(8'h7F);
    expect_write(8'h7F, 8'h01);
    send_byte(8'h01);
    expect_write(8'h00, 8'h02);
    send_byte(8'h02);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    idle_cycles(2);

    $display("[TB] abort during read wait");
    frame_begin();
    rd_q.push_back('{a: 8'h10, d: 8'h00, c: cyc + 1});
    send_byte(8'h90);
    idle_cycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("abort_busy", {15'd0, busy}, 16'd0);
    checkOutput("abort_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    idle_cycles(3);
    frame_begin();
    send_byte(8'h03);
    expect_write(8'h03, 8'hAB);
    send_byte(8'hAB);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    idle_cycles(2);

    $display("[TB] frame_end priority and idle bytes");
    frame_begin();
    send_byte(8'h20);
    expect_write(8'h20, 8'h55);
    send_byte(8'h55);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h66);
    checkOutput("prio_busy", {15'd0, busy}, 16'd0);
    send_byte(8'h44);
    send_byte(8'h85);
    idle_cycles(3);
    checkOutput("idle_rx_busy", {15'd0, busy}, 16'd0);

    $display("[TB] restart while busy");
    frame_begin();
    send_byte(8'h40);
    frame_begin();
    send_byte(8'h41);
    expect_write(8'h41, 8'h77);
    send_byte(8'h77);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    idle_cycles(2);

    $display("[TB] reset mid-transaction");
    frame_begin();
    send_byte(8'h81);
    checkOutput("pre_rst_reg_re", {15'd0, bus.reg_re}, 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_reg_re", {15'd0, bus.reg_re}, 16'd0);
    checkOutput("mid_rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("mid_rst_reg_addr", {9'd0, bus.reg_addr}, 16'd0);
    checkOutput("mid_rst_tx_byte", {8'd0, bus.tx_byte}, {8'd0, IDLE_TX});
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);

    checkOutput("wr_q_drained", 16'(wr_q.size()), 16'd0);
    checkOutput("rd_q_drained", 16'(rd_q.size()), 16'd0);
    checkOutput("tx_q_drained", 16'(tx_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
